serial_number_decoder: RTL and testbench

SERIAL_NUMBER_DECODER -- requirements
Module: serial_number_decoder

---
 rtl/serial_pkg.sv | 17 +
 rtl/serial_number_decoder.sv | 130 +++++++++++++
 tb/tb_serial_number_decoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial number encoder/decoder pair.
//
// Contents:
//   SERIAL_NUMBER_BITS  - default width of the signed fixed-point number
//   SERIAL_NUMBER_BYTES - bytes needed to carry one number on the UART link
//   state_t             - decoder framing state (COLLECT / HOLD)
package serial_pkg;

  localparam int SERIAL_NUMBER_BITS  = 37;
  localparam int SERIAL_NUMBER_BYTES = (SERIAL_NUMBER_BITS + 7) / 8;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/serial_number_decoder.sv
// Reassembles a signed fixed-point number from little-endian UART bytes.
//
// Ports:
//   clk           - clock
//   reset         - synchronous, active-high reset
//   receive_byte  - byte from the UART receiver
//   receive_valid - one-cycle pulse qualifying receive_byte
//   num           - assembled signed number, stable while num_valid is high
//   num_valid     - high while num holds an unconsumed number
//   num_ready     - consumer takes num when num_valid && num_ready
//   frame_error   - one-cycle pulse when a partial number times out
//   overrun       - one-cycle pulse when a byte is dropped while holding
module serial_number_decoder
  import serial_pkg::*;
#(
  parameter int NUMBER_BITS     = SERIAL_NUMBER_BITS,
  parameter int NUMBER_BYTES    = SERIAL_NUMBER_BYTES,
  parameter int BYTE_INDEX_BITS = 3,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int TIMEOUT_BITS    = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    receive_byte,
  input  logic                          receive_valid,
  output logic signed [NUMBER_BITS-1:0] num,
  output logic                          num_valid,
  input  logic                          num_ready,
  output logic                          frame_error,
  output logic                          overrun
);

  localparam int ASM_W = NUMBER_BYTES * 8;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [BYTE_INDEX_BITS-1:0]    r_byte_index;
  logic [TIMEOUT_BITS-1:0]       r_timeout;
  logic [ASM_W-1:0]              r_asm;
  logic [ASM_W-1:0]              w_asm_merged;
  logic signed [NUMBER_BITS-1:0] r_num;
  logic                          r_frame_error;
  logic                          r_overrun;

  logic w_consume;
  logic w_accept;
  logic w_drop;
  logic w_last;
  logic w_timeout_hit;

  // A byte arriving while a number is held is only taken if the held number
  // is consumed on the same edge; otherwise it is dropped as an overrun.
  assign w_consume     = (r_state == HOLD) && num_ready;
  assign w_accept      = receive_valid && ((r_state == COLLECT) || w_consume);
  assign w_drop        = receive_valid && (r_state == HOLD) && !num_ready;
  assign w_last        = w_accept &&
                         (r_byte_index == BYTE_INDEX_BITS'(NUMBER_BYTES - 1));
  // An arriving byte always wins over an expiring timeout.
  assign w_timeout_hit = (r_state == COLLECT) && !receive_valid &&
                         (r_byte_index != '0) &&
                         (r_timeout == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));

  // Assembly value including the byte arriving this cycle, so the final
  // byte can be loaded into num on the same edge it is accepted.
  always_comb begin
    w_asm_merged = r_asm;
    w_asm_merged[{r_byte_index, 3'b000} +: 8] = receive_byte;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (w_last) w_state_next = HOLD;
      HOLD:    if (w_consume) w_state_next = w_last ? HOLD : COLLECT;
      default: w_state_next = COLLECT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    num_valid   = (r_state == HOLD);
    num         = r_num;
    frame_error = r_frame_error;
    overrun     = r_overrun;
  end

  // Byte counter, timeout counter, assembly and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_index  <= '0;
      r_timeout     <= '0;
      r_asm         <= '0;
      r_num         <= '0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_error <= w_timeout_hit;
      r_overrun     <= w_drop;

      if (w_accept) begin
        r_asm        <= w_asm_merged;
        r_timeout    <= '0;
        r_byte_index <= w_last ? '0 : r_byte_index + 1'b1;
      end else if (w_timeout_hit) begin
        r_byte_index <= '0;
        r_timeout    <= '0;
      end else if ((r_state == COLLECT) && (r_byte_index != '0)) begin
        r_timeout    <= r_timeout + 1'b1;
      end else begin
        r_timeout    <= '0;
      end

      // Bits above NUMBER_BITS in the final byte are simply truncated.
      if (w_last) begin
        r_num <= $signed(w_asm_merged[NUMBER_BITS-1:0]);
      end
    end
  end

endmodule

// File: tb/tb_serial_number_decoder.sv
module tb_serial_number_decoder;

  localparam int NB  = 37;
  localparam int NBY = 5;
  localparam int TO  = 100;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [7:0]           receive_byte = 8'h00;
  logic                 receive_valid = 1'b0;
  logic signed [NB-1:0] num;
  logic                 num_valid;
  logic                 num_ready = 1'b0;
  logic                 frame_error;
  logic                 overrun;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  serial_number_decoder #(
    .NUMBER_BITS    (NB),
    .NUMBER_BYTES   (NBY),
    .BYTE_INDEX_BITS(3),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_BITS   (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .receive_byte (receive_byte),
    .receive_valid(receive_valid),
    .num          (num),
    .num_valid    (num_valid),
    .num_ready    (num_ready),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: bytes are queued until a full number is present, then
  // packed little-endian and truncated to NB bits.
  logic [7:0]    m_q[$];
  logic          m_valid = 1'b0;
  logic [NB-1:0] m_num = '0;
  logic          m_fe = 1'b0;
  logic          m_ov = 1'b0;
  int            m_idle = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_valid = 1'b0;
      m_num   = '0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
      m_idle  = 0;
    end else begin
      logic consume;
      consume = m_valid && num_ready;
      m_fe = 1'b0;
      m_ov = 1'b0;
      if (receive_valid) begin
        if (m_valid && !num_ready) begin
          m_ov = 1'b1;
        end else begin
          m_q.push_back(receive_byte);
          m_idle = 0;
        end
      end else if (m_q.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_q.delete();
          m_idle = 0;
          m_fe = 1'b1;
        end
      end
      if (consume) m_valid = 1'b0;
      if (m_q.size() == NBY) begin
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NBY; i++) v = v | (64'(m_q[i]) << (8 * i));
        m_num   = v[NB-1:0];
        m_valid = 1'b1;
        m_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    check("num_valid", 64'(num_valid), 64'(m_valid));
    check("num", 64'($unsigned(num)), 64'(m_num));
    check("frame_error", 64'(frame_error), 64'(m_fe));
    check("overrun", 64'(overrun), 64'(m_ov));
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    receive_valid = 1'b1;
    receive_byte  = b;
    @(posedge clk);
    #1;
    receive_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int fe0;
    int ov0;
    idle(3);
    reset = 1'b0;
    check("reset num", 64'($unsigned(num)), 64'h0);
    check("reset num_valid", 64'(num_valid), 64'h0);
    idle(2);

    // Basic little-endian assembly with ready held high
    num_ready = 1'b1;
    send_byte(8'h89); send_byte(8'h67); send_byte(8'h45); send_byte(8'h23);
    send_byte(8'h01);
    check("s1 valid", 64'(num_valid), 64'h1);
    check("s1 num", 64'($unsigned(num)), 64'h01_2345_6789);
    idle(1);
    check("s1 valid one cycle", 64'(num_valid), 64'h0);
    idle(2);

    // Negative value, bits above 37 discarded
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hFF);
    check("s2 num", 64'($unsigned(num)), 64'h1F_0000_0000);
    check("s2 negative", 64'(num < 0), 64'h1);
    idle(2);
    check("s2 no errors", 64'(fe_cnt - fe0 + ov_cnt - ov0), 64'h0);

    // Timeout of a partial number
    fe0 = fe_cnt;
    send_byte(8'h11); send_byte(8'h22);
    idle(TO + 3);
    check("s3 frame_error pulses", 64'(fe_cnt - fe0), 64'h1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h01);
    check("s3 num", 64'($unsigned(num)), 64'h01_DDCC_BBAA);
    idle(2);

    // Byte arriving on the timeout cycle is accepted
    fe0 = fe_cnt;
    send_byte(8'h10);
    idle(TO - 1);
    send_byte(8'h20);
    send_byte(8'h30); send_byte(8'h40); send_byte(8'h05);
    check("s3b no frame_error", 64'(fe_cnt - fe0), 64'h0);
    check("s3b num", 64'($unsigned(num)), 64'h05_4030_2010);
    idle(2);

    // Overrun while holding, then consume together with the next byte
    num_ready = 1'b0;
    ov0 = ov_cnt;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    idle(1);
    send_byte(8'h55);
    idle(1);
    check("s4 overrun pulses", 64'(ov_cnt - ov0), 64'h1);
    check("s4 num held", 64'($unsigned(num)), 64'h05_0403_0201);
    check("s4 still valid", 64'(num_valid), 64'h1);
    num_ready = 1'b1;
    send_byte(8'h77);
    check("s4 consumed", 64'(num_valid), 64'h0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("s4 num", 64'($unsigned(num)), 64'h77);
    check("s4 valid", 64'(num_valid), 64'h1);
    check("s4 single overrun", 64'(ov_cnt - ov0), 64'h1);
    idle(2);

    // Reset mid-number
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("s5 num", 64'($unsigned(num)), 64'h0);
    check("s5 valid", 64'(num_valid), 64'h0);
    check("s5 fe", 64'(frame_error), 64'h0);
    check("s5 ov", 64'(overrun), 64'h0);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h0A);
    check("s5 fresh num", 64'($unsigned(num)), 64'h0A_7856_3412);
    idle(TO + 5);
    check("s5 no error pulses", 64'(fe_cnt - fe0 + ov_cnt - ov0), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
